regfile_wb_arbiter: RTL

Shares the single write port of the integer register file (Registers) among N writeback requesters, e.g. ALU, load unit and mul/div unit. Arbitration is round-robin with a valid/ready handshake per requester. The winning write is registered, then driven onto the register-file write port (wr_en_i, RD_ADDR_i, data_i) for exactly one cycle. The block sits between the execute/memory stages and Registers.

---
 rtl/regfile_wb_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//   Round-robin arbiter that shares the single write port of the integer
//   register file among N_REQ writeback requesters (ALU, load unit, mul/div).
//   Each requester uses a valid/ready handshake. The winning write is
//   registered and presented to the register file for exactly one cycle.
//
// Ports
//   clk          clock, all state on rising edge
//   rst          synchronous active-high reset
//   req_valid_i  [N_REQ]             requester k has a write pending
//   req_ready_o  [N_REQ]             requester k accepted this cycle (one-hot or zero)
//   req_addr_i   [N_REQ*ADDR_WIDTH]  packed destination index, slice k = requester k
//   req_data_i   [N_REQ*DATA_WIDTH]  packed write data, slice k = requester k
//   stall_i      pipeline hold, suppresses all grants
//   wr_en_o      register-file write enable
//   rd_addr_o    register-file write index
//   data_o       register-file write data
//   grant_idx_o  index of the last accepted requester (debug)
//
// Optional feature (macro REGFILE_WB_ARB_FWD_EN)
//   Adds two combinational forwarding lookups (a/b) against the write that is
//   currently on the register-file port and not yet committed:
//   fwd_addr_a_i/fwd_addr_b_i in, fwd_hit_a_o/fwd_hit_b_o and
//   fwd_data_a_o/fwd_data_b_o out.
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter  int N_REQ      = 3,
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 5,
  localparam int IDX_W      = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid_i,
  output logic [N_REQ-1:0]            req_ready_o,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic                        stall_i,
  output logic                        wr_en_o,
  output logic [ADDR_WIDTH-1:0]       rd_addr_o,
  output logic [DATA_WIDTH-1:0]       data_o,
  output logic [IDX_W-1:0]            grant_idx_o
`ifdef REGFILE_WB_ARB_FWD_EN
  ,
  input  logic [ADDR_WIDTH-1:0]       fwd_addr_a_i,
  input  logic [ADDR_WIDTH-1:0]       fwd_addr_b_i,
  output logic                        fwd_hit_a_o,
  output logic                        fwd_hit_b_o,
  output logic [DATA_WIDTH-1:0]       fwd_data_a_o,
  output logic [DATA_WIDTH-1:0]       fwd_data_b_o
`endif
);

  logic [ADDR_WIDTH-1:0] addr_slice [N_REQ];
  logic [DATA_WIDTH-1:0] data_slice [N_REQ];

  logic [IDX_W-1:0]      ptr_reg, ptr_next;
  logic                  wr_en_reg, wr_en_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [DATA_WIDTH-1:0] data_reg, data_next;
  logic [IDX_W-1:0]      gidx_reg, gidx_next;

  logic                  grant_any;
  logic [IDX_W-1:0]      grant_idx;
  logic                  accept;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign addr_slice[gi]  = req_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign data_slice[gi]  = req_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
      assign req_ready_o[gi] = accept && (grant_idx == IDX_W'(gi));
    end
  endgenerate

  // Search from the pointer upward with wrap-around. Iterating the offsets
  // from highest to lowest lets the smallest offset (first in RR order) win.
  always_comb begin
    int cand;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = (int'(ptr_reg) + i) % N_REQ;
      if (req_valid_i[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand[IDX_W-1:0];
      end
    end
  end

  // No acceptance while stalled or while reset is asserted.
  assign accept = grant_any && !stall_i && !rst;

  always_comb begin
    ptr_next   = ptr_reg;
    wr_en_next = 1'b0;
    addr_next  = addr_reg;
    data_next  = data_reg;
    gidx_next  = gidx_reg;
    if (accept) begin
      ptr_next  = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      gidx_next = grant_idx;
      // Writes to x0 are consumed without touching the register-file port;
      // the last real write's address/data stay on the bus.
      if (addr_slice[grant_idx] != '0) begin
        wr_en_next = 1'b1;
        addr_next  = addr_slice[grant_idx];
        data_next  = data_slice[grant_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg   <= '0;
      wr_en_reg <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
      gidx_reg  <= '0;
    end else begin
      ptr_reg   <= ptr_next;
      wr_en_reg <= wr_en_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      gidx_reg  <= gidx_next;
    end
  end

  assign wr_en_o     = wr_en_reg;
  assign rd_addr_o   = addr_reg;
  assign data_o      = data_reg;
  assign grant_idx_o = gidx_reg;

`ifdef REGFILE_WB_ARB_FWD_EN
  // Bypass for the cycle before the register file commits the write.
  assign fwd_hit_a_o  = wr_en_reg && (addr_reg == fwd_addr_a_i) && (fwd_addr_a_i != '0);
  assign fwd_hit_b_o  = wr_en_reg && (addr_reg == fwd_addr_b_i) && (fwd_addr_b_i != '0);
  assign fwd_data_a_o = fwd_hit_a_o ? data_reg : '0;
  assign fwd_data_b_o = fwd_hit_b_o ? data_reg : '0;
`endif

endmodule
